control_hazard_sequencer: RTL and testbench

//   Parametrised ID-stage control-hazard unit for B/BR/PCS branches. Compares the

---
 rtl/control_hazard_sequencer.sv | 148 ++++++++++++++
 tb/tb_control_hazard_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_hazard_sequencer.sv
// Control-hazard sequencer for B/BR/PCS branches sitting beside IF/ID.
// Works out how many bubbles a branch in ID needs from the flag and
// register producers still in flight, then holds the front end for that many
// cycles, honouring external hold and flush.
// Optional build macro: CTRL_HAZ_BR_FWD_EN (EX/MEM->ID forwarding of the BR
// target, which shortens every register hit by one cycle).
module control_hazard_sequencer #(
  parameter int REG_W  = 4,
  parameter int STAGES = 2,
  localparam int CNT_W = $clog2(STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trigger,
  input  logic [1:0]                br_type,
  input  logic [REG_W-1:0]          src_reg,
  input  logic                      ex_flag_wr,
  input  logic [STAGES-1:0]         stg_rf_wr,
  input  logic [STAGES*REG_W-1:0]   stg_dst,
  input  logic                      hold,
  input  logic                      flush,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_remaining,
  output logic                      stall_done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  // In STALL the counter holds the stall cycles still owed after the current one.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_done;
  logic             w_done_next;

  logic [CNT_W-1:0] w_stage_need [STAGES];
  logic [CNT_W-1:0] w_reg_need;
  logic [CNT_W-1:0] w_flag_need;
  logic [CNT_W-1:0] w_need;
  logic             w_stall;
  logic [CNT_W-1:0] w_remaining;

  // A producer in stage i that writes the BR target register costs the bubbles
  // needed for it to reach the point where its result becomes visible to ID.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic w_hit;
      assign w_hit = stg_rf_wr[gi] && (stg_dst[gi*REG_W +: REG_W] == src_reg);
`ifdef CTRL_HAZ_BR_FWD_EN
      assign w_stage_need[gi] = w_hit ? CNT_W'(STAGES - 1 - gi) : '0;
`else
      assign w_stage_need[gi] = w_hit ? CNT_W'(STAGES - gi) : '0;
`endif
    end
  endgenerate

  assign w_flag_need = CNT_W'(ex_flag_wr);

  // Combinational stall need for the branch currently in ID.
  always_comb begin
    w_reg_need = '0;
    w_need     = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (w_stage_need[i] > w_reg_need) begin
        w_reg_need = w_stage_need[i];
      end
    end
    if (trigger) begin
      case (br_type)
        2'd0:    w_need = w_flag_need;
        2'd1:    w_need = (w_reg_need > w_flag_need) ? w_reg_need : w_flag_need;
        default: w_need = '0;
      endcase
    end
  end

  // Next-state, counter, done pulse and stall outputs; flush then reset override.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    w_stall      = 1'b0;
    w_remaining  = '0;
    case (r_state)
      S_IDLE: begin
        w_stall     = (w_need != '0) && !flush;
        w_remaining = w_stall ? (w_need - CNT_W'(1)) : '0;
        if (w_stall && !hold) begin
          if (w_need > CNT_W'(1)) begin
            w_state_next = S_STALL;
            w_cnt_next   = w_need - CNT_W'(2);
          end else begin
            w_cnt_next  = '0;
            w_done_next = 1'b1;
          end
        end
      end
      S_STALL: begin
        w_stall     = !flush;
        w_remaining = r_cnt;
        if (!hold) begin
          if (r_cnt == '0) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_done_next  = 1'b0;
    end
    if (!rst_n) begin
      w_stall     = 1'b0;
      w_remaining = '0;
    end
  end

  // State, counter and done-pulse registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  assign stall           = w_stall;
  assign stall_remaining = w_remaining;
  assign stall_done      = r_done;

endmodule

// File: tb/tb_control_hazard_sequencer.sv
// Self-checking bench for control_hazard_sequencer: directed scenarios with
// literal expectations, then randomized traffic against a count-down model.
module tb_control_hazard_sequencer;
  localparam int REG_W  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = $clog2(STAGES + 1);

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    trigger;
  logic [1:0]              br_type;
  logic [REG_W-1:0]        src_reg;
  logic                    ex_flag_wr;
  logic [STAGES-1:0]       stg_rf_wr;
  logic [STAGES*REG_W-1:0] stg_dst;
  logic                    hold;
  logic                    flush;
  logic                    stall;
  logic [CNT_W-1:0]        stall_remaining;
  logic                    stall_done;

  int checks = 0;
  int errors = 0;
  // Model: stall cycles left in the current sequence, counting the present one.
  int left   = 0;
  bit done_m = 1'b0;

  always #5 clk = ~clk;

  control_hazard_sequencer #(.REG_W(REG_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .br_type(br_type),
    .src_reg(src_reg), .ex_flag_wr(ex_flag_wr), .stg_rf_wr(stg_rf_wr),
    .stg_dst(stg_dst), .hold(hold), .flush(flush), .stall(stall),
    .stall_remaining(stall_remaining), .stall_done(stall_done)
  );

  function automatic int need_of();
    int n;
    int h;
    if (!trigger) return 0;
    if (br_type == 2'd0) return ex_flag_wr ? 1 : 0;
    if (br_type != 2'd1) return 0;
    n = ex_flag_wr ? 1 : 0;
    for (int i = 0; i < STAGES; i++) begin
      if (stg_rf_wr[i] && stg_dst[i*REG_W +: REG_W] == src_reg) begin
`ifdef CTRL_HAZ_BR_FWD_EN
        h = STAGES - 1 - i;
`else
        h = STAGES - i;
`endif
        if (h > n) n = h;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock: update the model with the inputs seen at the edge.
  task automatic tick();
    int n;
    @(posedge clk);
    if (!rst_n) begin
      left = 0; done_m = 1'b0;
    end else if (left > 0) begin
      if (flush) begin
        left = 0; done_m = 1'b0;
      end else if (hold) begin
        done_m = 1'b0;
      end else begin
        left--; done_m = (left == 0);
      end
    end else begin
      n = need_of();
      if (flush || hold || n == 0) begin
        done_m = 1'b0;
      end else begin
        left = n - 1; done_m = (n == 1);
      end
    end
    #1;
  endtask

  // Compare DUT outputs against the model at the falling edge.
  task automatic compare(input string tag);
    int n, es, er;
    @(negedge clk);
    if (!rst_n) begin
      left = 0; done_m = 1'b0;
    end
    es = 0; er = 0;
    if (rst_n) begin
      if (left > 0) begin
        es = flush ? 0 : 1;
        er = left - 1;
      end else begin
        n  = need_of();
        es = (n > 0 && !flush) ? 1 : 0;
        er = es ? n - 1 : 0;
      end
    end
    check({tag, ".stall"}, int'(stall), es);
    check({tag, ".remaining"}, int'(stall_remaining), er);
    check({tag, ".done"}, int'(stall_done), int'(done_m));
  endtask

  task automatic quiet();
    trigger = 0; br_type = 0; src_reg = 0; ex_flag_wr = 0;
    stg_rf_wr = '0; stg_dst = '0; hold = 0; flush = 0;
  endtask

  task automatic br_ex_hit();
    trigger = 1; br_type = 2'd1; src_reg = 4'd5;
    stg_rf_wr = 2'b01; stg_dst = {4'd0, 4'd5};
  endtask

  initial begin
    int cnt;
    rst_n = 0;
    quiet();
    tick(); tick();
    rst_n = 1;
    compare("reset");
    check("reset.lit_stall", int'(stall), 0);

    // 1: B with flag producer in EX -> single stall, done next cycle.
    tick(); trigger = 1; br_type = 2'd0; ex_flag_wr = 1;
    compare("t1a"); check("t1.lit_stall", int'(stall), 1);
    check("t1.lit_rem", int'(stall_remaining), 0);
    tick(); quiet();
    compare("t1b"); check("t1.lit_done", int'(stall_done), 1);
    check("t1.lit_stall_off", int'(stall), 0);
    tick(); compare("t1c"); check("t1.lit_done_off", int'(stall_done), 0);
    $display("tb: B flag hazard scenario complete");

    // 2: BR with EX hit.
    tick(); br_ex_hit();
    compare("t2a");
`ifdef CTRL_HAZ_BR_FWD_EN
    check("t2.lit_rem0", int'(stall_remaining), 0);
    tick(); quiet(); compare("t2b");
    check("t2.lit_stall1", int'(stall), 0);
    check("t2.lit_done1", int'(stall_done), 1);
`else
    check("t2.lit_rem0", int'(stall_remaining), 1);
    tick(); quiet(); compare("t2b");
    check("t2.lit_stall1", int'(stall), 1);
    check("t2.lit_rem1", int'(stall_remaining), 0);
    tick(); compare("t2c");
    check("t2.lit_stall2", int'(stall), 0);
    check("t2.lit_done2", int'(stall_done), 1);
`endif
    tick(); quiet(); compare("t2d");
    $display("tb: BR EX-hit scenario complete");

    // 3: MEM hit plus flag -> one stall; PCS with same hits -> none.
    tick(); trigger = 1; br_type = 2'd1; src_reg = 4'd5; ex_flag_wr = 1;
    stg_rf_wr = 2'b10; stg_dst = {4'd5, 4'd0};
    compare("t3a"); check("t3.lit_stall", int'(stall), 1);
    check("t3.lit_rem", int'(stall_remaining), 0);
    tick(); br_type = 2'd2;
    compare("t3b"); check("t3.lit_pcs", int'(stall), 0);
    tick(); quiet(); compare("t3c");
    $display("tb: mixed hazard / PCS scenario complete");

    // 4: BR EX hit with hold for 3 cycles once stalling.
    tick(); br_ex_hit(); cnt = 0;
    for (int c = 0; c < 7; c++) begin
      compare("t4");
      cnt += int'(stall);
      tick();
      if (c == 0) begin quiet(); hold = 1; end
      if (c == 3) hold = 0;
    end
`ifdef CTRL_HAZ_BR_FWD_EN
    check("t4.lit_stall_cycles", cnt, 1);
`else
    check("t4.lit_stall_cycles", cnt, 5);
`endif
    quiet();
    $display("tb: hold-in-stall scenario complete, %0d stall cycles", cnt);

    // 5: flush while stalling -> stall drops, no done pulse afterwards.
    tick(); br_ex_hit();
    compare("t5a");
    tick(); quiet(); flush = 1;
    compare("t5b"); check("t5.lit_stall", int'(stall), 0);
    tick(); flush = 0;
    compare("t5c"); check("t5.lit_done1", int'(stall_done), 0);
    check("t5.lit_stall_after", int'(stall), 0);
    tick(); compare("t5d"); check("t5.lit_done2", int'(stall_done), 0);
    $display("tb: flush-in-stall scenario complete");

    // 6: async reset mid-stall.
    tick(); br_ex_hit();
    compare("t6a");
    tick(); quiet(); rst_n = 0; #1;
    check("t6.lit_stall_rst", int'(stall), 0);
    check("t6.lit_rem_rst", int'(stall_remaining), 0);
    compare("t6b");
    tick(); rst_n = 1;
    compare("t6c"); check("t6.lit_stall_post", int'(stall), 0);
    $display("tb: reset-mid-stall scenario complete");

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      tick();
      trigger    = ($urandom_range(0, 9) < 6);
      br_type    = 2'($urandom_range(0, 3));
      src_reg    = REG_W'($urandom_range(0, 3));
      ex_flag_wr = ($urandom_range(0, 3) == 0);
      stg_rf_wr  = STAGES'($urandom);
      stg_dst    = {REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3))};
      hold       = ($urandom_range(0, 6) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      rst_n      = ($urandom_range(0, 99) != 0);
      compare("rand");
    end
    $display("tb: randomized phase complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
